// File: rtl/manhattan_distance_if.sv
// manhattan_distance_if: bus bundle for the L1 distance unit.
//   master drives en/axis/a/b/c; slave returns dist_out/single_dist_out/done.
//   Widths follow the unit's derived sizes for the given dim/data_range.
interface manhattan_distance_if #(
    parameter int dim        = 3,
    parameter int data_range = 255
);
    localparam int dim_size    = $clog2(data_range);
    localparam int center_size = dim * dim_size;
    localparam int dist_size   = $clog2(data_range * dim);
    localparam int axis_w      = ($clog2(dim) < 1) ? 1 : $clog2(dim);
    logic                   en;
    logic [axis_w-1:0]      axis;
    logic [center_size-1:0] a;
    logic [center_size-1:0] b;
    logic [center_size-1:0] c;
    logic [dist_size-1:0]   dist_out;
    logic [dim_size-1:0]    single_dist_out;
    logic                   done;
    modport master (output en, axis, a, b, c, input dist_out, single_dist_out, done);
    modport slave  (input en, axis, a, b, c, output dist_out, single_dist_out, done);
endinterface

// File: rtl/manhattan_distance.sv
// manhattan_distance: registered L1 distance and split-axis distance between a node center and a query point.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : manhattan_distance_if.slave (en, axis, a, b, c in; dist_out, single_dist_out, done out)
//   Optional macro MANHATTAN_PIPE_EN inserts a register between the absolute
//   differences and the adder, making latency 2 cycles at full throughput.
module manhattan_distance #(
    parameter int dim        = 3,
    parameter int data_range = 255
) (
    input logic clk,
    input logic rst,
    manhattan_distance_if.slave bus
);
    localparam int dim_size  = $clog2(data_range);
    localparam int dist_size = $clog2(data_range * dim);
    localparam int sum_w     = dist_size + 1;
    logic [dim-1:0][dim_size-1:0] diff;
    logic [dim_size-1:0]          sel;
    logic [dim-1:0][dim_size-1:0] d_src;
    logic [dim_size-1:0]          s_src;
    logic                         v_src;
    logic [sum_w-1:0]             sum;
    // Magnitude compare per coordinate; axis values past the last coordinate fall back to dim-1.
    always_comb begin
        sel = '0;
        for (int k = 0; k < dim; k++) begin
            diff[k] = (bus.a[k*dim_size +: dim_size] >= bus.b[k*dim_size +: dim_size])
                    ? bus.a[k*dim_size +: dim_size] - bus.b[k*dim_size +: dim_size]
                    : bus.b[k*dim_size +: dim_size] - bus.a[k*dim_size +: dim_size];
        end
        sel = diff[dim-1];
        for (int k = 0; k < dim - 1; k++)
            if (int'(bus.axis) == k) sel = diff[k];
    end
`ifdef MANHATTAN_PIPE_EN
    logic [dim-1:0][dim_size-1:0] diff_q;
    logic [dim_size-1:0]          sel_q;
    logic                         vld_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            diff_q <= '0;
            sel_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= bus.en;
            if (bus.en) begin
                diff_q <= diff;
                sel_q  <= sel;
            end
        end
    end
    assign d_src = diff_q;
    assign s_src = sel_q;
    assign v_src = vld_q;
`else
    assign d_src = diff;
    assign s_src = sel;
    assign v_src = bus.en;
`endif
    // One spare bit catches overflow so the result can saturate.
    always_comb begin
        sum = '0;
        for (int k = 0; k < dim; k++) sum = sum + sum_w'(d_src[k]);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dist_out        <= '0;
            bus.single_dist_out <= '0;
            bus.done            <= 1'b0;
        end else begin
            bus.done <= v_src;
            if (v_src) begin
                bus.dist_out        <= sum[dist_size] ? '1 : sum[dist_size-1:0];
                bus.single_dist_out <= s_src;
            end
        end
    end
endmodule

// File: tb/tb_manhattan_distance.sv
// tb_manhattan_distance: directed plus randomized checks of manhattan_distance against an arithmetic reference.
module tb_manhattan_distance;
`ifdef MANHATTAN_PIPE_EN
    localparam int lat = 2;
`else
    localparam int lat = 1;
`endif
    typedef struct {
        logic v;
        int   d;
        int   s;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    manhattan_distance_if #(.dim(3), .data_range(255)) bus ();
    manhattan_distance #(.dim(3), .data_range(255)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int   npass = 0;
    int   ntot  = 0;
    int   nfail = 0;
    ent_t q[$];
    int   od, os;
    logic odone;
    logic cen;
    int   cax;
    int   ca[3];
    int   cb[3];
    function automatic int absd(int x, int y);
        return (x > y) ? x - y : y - x;
    endfunction
    function automatic int ref_dist();
        int s = 0;
        for (int k = 0; k < 3; k++) s += absd(ca[k], cb[k]);
        return (s > 1023) ? 1023 : s;
    endfunction
    function automatic int ref_single();
        int k = (cax >= 3) ? 2 : cax;
        return absd(ca[k], cb[k]);
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        q.delete();
        for (int i = 0; i < lat - 1; i++) q.push_back('{1'b0, 0, 0});
        od = 0;
        os = 0;
        odone = 1'b0;
    endtask
    task automatic check_outs(input string tag);
        chk({tag, "_done"}, 32'(bus.done), 32'(odone));
        chk({tag, "_dist"}, 32'(bus.dist_out), 32'(od));
        chk({tag, "_single"}, 32'(bus.single_dist_out), 32'(os));
    endtask
    task automatic tick(input string tag);
        ent_t e;
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            q.push_back('{cen, ref_dist(), ref_single()});
            e = q.pop_front();
            odone = e.v;
            if (e.v) begin
                od = e.d;
                os = e.s;
            end
        end
        @(negedge clk);
        check_outs(tag);
    endtask
    task automatic drive(input logic e, input int ax, input int a0, input int a1, input int a2,
                         input int b0, input int b1, input int b2);
        cen = e;
        cax = ax;
        ca = '{a0, a1, a2};
        cb = '{b0, b1, b2};
        bus.en   = e;
        bus.axis = 2'(ax);
        bus.a    = {8'(a2), 8'(a1), 8'(a0)};
        bus.b    = {8'(b2), 8'(b1), 8'(b0)};
        bus.c    = 24'($urandom);
    endtask
    task automatic drive_rand(input logic e);
        drive(e, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255));
    endtask
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cen = 1'b0;
            bus.en = 1'b0;
            bus.c = 24'($urandom);
            tick(tag);
        end
    endtask
    initial begin
        model_reset();
        drive_rand(1'b1);
        #1 check_outs("reset0");
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            tick("reset_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 0, 10, 20, 30, 13, 15, 30);
        tick("basic_ax0");
        idle(lat, "basic_ax0_after");
        chk("basic_dist_const", 32'(bus.dist_out), 32'd8);
        chk("basic_single_const", 32'(bus.single_dist_out), 32'd3);
        drive(1'b1, 1, 10, 20, 30, 13, 15, 30);
        tick("basic_ax1");
        idle(lat, "basic_ax1_after");
        chk("basic_ax1_single_const", 32'(bus.single_dist_out), 32'd5);
        drive(1'b1, 2, 255, 255, 255, 0, 0, 0);
        tick("ext");
        drive(1'b1, 2, 0, 0, 0, 255, 255, 255);
        tick("ext_swap");
        idle(lat - 1, "ext_drain");
        chk("ext_swap_dist_const", 32'(bus.dist_out), 32'd765);
        chk("ext_swap_single_const", 32'(bus.single_dist_out), 32'd255);
        drive(1'b1, 1, 77, 200, 3, 77, 200, 3);
        tick("equal");
        idle(lat, "equal_after");
        chk("equal_dist_const", 32'(bus.dist_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b1);
            tick("stream4");
        end
        idle(3, "stream4_hold");
        drive(1'b1, 3, 1, 2, 100, 1, 2, 40);
        tick("axis_oob");
        idle(lat, "axis_oob_after");
        chk("axis_oob_single_const", 32'(bus.single_dist_out), 32'd60);
        for (int i = 0; i < 40; i++) begin
            drive_rand(1'($urandom_range(0, 1)));
            tick("rand");
        end
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            tick("pre_rst_stream");
        end
        #2 rst = 1'b0;
        #1 model_reset();
        check_outs("async_rst");
        drive_rand(1'b1);
        tick("in_rst");
        rst = 1'b1;
        idle(lat + 1, "post_rst");
        for (int i = 0; i < 40; i++) begin
            drive_rand(1'($urandom_range(0, 1)));
            tick("rand2");
        end
        idle(lat, "final");
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
